// File: rtl/lcd_pkg.sv
// Shared LCD types: arbiter state encoding, display geometry and the write payload.
package lcd_pkg;

    localparam int unsigned LCD_ROWS  = 2;
    localparam int unsigned LCD_COLS  = 16;
    localparam int unsigned LCD_ROW_W = 2;
    localparam int unsigned LCD_COL_W = 4;
    localparam int unsigned LCD_CHR_W = 8;

    typedef enum logic [0:0] {
        LCD_ARB_IDLE = 1'b0,
        LCD_ARB_WAIT = 1'b1
    } lcd_arb_state_t;

    // One character write: position plus character code.
    typedef struct packed {
        logic [LCD_ROW_W-1:0] row;
        logic [LCD_COL_W-1:0] col;
        logic [LCD_CHR_W-1:0] chr;
    } lcd_wr_t;

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester-side and driver-side handshake bundle of the LCD write arbiter.
interface lcd_write_arbiter_if
    import lcd_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) ();

    logic [N_REQ-1:0]           req_en;
    logic [N_REQ-1:0]           req_valid;
    logic [LCD_ROW_W*N_REQ-1:0] req_row_flat;
    logic [LCD_COL_W*N_REQ-1:0] req_col_flat;
    logic [LCD_CHR_W*N_REQ-1:0] req_char_flat;
    logic [N_REQ-1:0]           req_busy;
    logic [N_REQ-1:0]           req_done;

    logic                       drv_req;
    logic [LCD_ROW_W-1:0]       drv_row;
    logic [LCD_COL_W-1:0]       drv_col;
    logic [LCD_CHR_W-1:0]       drv_char;
    logic                       drv_busy;
    logic                       drv_done;

    // Screens and LCD driver side.
    modport master (
        output req_en, req_valid, req_row_flat, req_col_flat, req_char_flat,
        output drv_busy, drv_done,
        input  req_busy, req_done,
        input  drv_req, drv_row, drv_col, drv_char
    );

    // Arbiter side.
    modport slave (
        input  req_en, req_valid, req_row_flat, req_col_flat, req_char_flat,
        input  drv_busy, drv_done,
        output req_busy, req_done,
        output drv_req, drv_row, drv_col, drv_char
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin first-set search: lowest set index at or after rr_ptr, with wrap.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pend,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan N positions starting at rr_ptr; first hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            int unsigned j;
            j = 32'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && pend[IDX_W'(j)]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the LCD driver character-write port among N_REQ screens: one buffered
// write per requester, round-robin grant, done routing and a WAIT watchdog.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_write_arbiter_if.slave  bus,
    input  logic                err_clr,
    output logic                ovf_err,
    output logic                tmo_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    lcd_arb_state_t           state_q, state_d;
    logic [N_REQ-1:0]         pend_q, pend_d;
    lcd_wr_t [N_REQ-1:0]      slot_q, slot_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     drv_req_q, drv_req_d;
    lcd_wr_t                  drv_q, drv_d;
    logic [N_REQ-1:0]         done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic                     tmo_q, tmo_d;

    logic [N_REQ-1:0]         busy_c;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic [IDX_W-1:0]         ptr_after_owner;
    logic                     grant;
    logic                     ovf_evt;
    logic                     tmo_evt;

    rr_pick #(.N(N_REQ)) u_pick (
        .pend   (pend_q),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Busy: slot pending, or this requester owns the transaction in flight.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            busy_c[i] = pend_q[i] | ((state_q == LCD_ARB_WAIT) && (owner_q == IDX_W'(i)));
        end
    end

    assign ptr_after_owner = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

    // Next state: grant/complete/timeout, slot capture and sticky errors.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        slot_d    = slot_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        drv_req_d = 1'b0;
        drv_d     = drv_q;
        done_d    = '0;
        grant     = 1'b0;
        ovf_evt   = 1'b0;
        tmo_evt   = 1'b0;

        case (state_q)
            LCD_ARB_IDLE: begin
                if (pick_any && !bus.drv_busy) begin
                    grant     = 1'b1;
                    state_d   = LCD_ARB_WAIT;
                    owner_d   = pick_idx;
                    drv_d     = slot_q[pick_idx];
                    drv_req_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            LCD_ARB_WAIT: begin
                if (bus.drv_done) begin
                    done_d[owner_q] = 1'b1;
                    rr_ptr_d        = ptr_after_owner;
                    state_d         = LCD_ARB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done_d[owner_q] = 1'b1;
                    rr_ptr_d        = ptr_after_owner;
                    tmo_evt         = 1'b1;
                    state_d         = LCD_ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = LCD_ARB_IDLE;
        endcase

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!bus.req_en[i]) begin
                pend_d[i] = 1'b0;
            end else if (bus.req_valid[i]) begin
                if (busy_c[i]) begin
                    ovf_evt = 1'b1;
                end else begin
                    pend_d[i]     = 1'b1;
                    slot_d[i].row = bus.req_row_flat[LCD_ROW_W*i +: LCD_ROW_W];
                    slot_d[i].col = bus.req_col_flat[LCD_COL_W*i +: LCD_COL_W];
                    slot_d[i].chr = bus.req_char_flat[LCD_CHR_W*i +: LCD_CHR_W];
                end
            end
        end

        // A granted slot was busy, so no capture can collide with this clear.
        if (grant) begin
            pend_d[pick_idx] = 1'b0;
        end

        ovf_d = (ovf_q & ~err_clr) | ovf_evt;
        tmo_d = (tmo_q & ~err_clr) | tmo_evt;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LCD_ARB_IDLE;
            pend_q    <= '0;
            slot_q    <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            drv_req_q <= 1'b0;
            drv_q     <= '0;
            done_q    <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            slot_q    <= slot_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            drv_req_q <= drv_req_d;
            drv_q     <= drv_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.req_busy = busy_c;
    assign bus.req_done = done_q;
    assign bus.drv_req  = drv_req_q;
    assign bus.drv_row  = drv_q.row;
    assign bus.drv_col  = drv_q.col;
    assign bus.drv_char = drv_q.chr;
    assign ovf_err      = ovf_q;
    assign tmo_err      = tmo_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios, a transaction-level model
// compared every cycle, and literal expectations at the key points.
module tb_lcd_write_arbiter;
    import lcd_pkg::*;

    localparam int N = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic ovf_err, tmo_err;

    lcd_write_arbiter_if #(.N_REQ(N)) bus ();

    lcd_write_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .ovf_err (ovf_err),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_pend [N];
    logic [1:0] m_row  [N];
    logic [3:0] m_col  [N];
    logic [7:0] m_chr  [N];
    bit         m_fly   = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_edges = 0;
    logic       e_drv_req = 0;
    logic [1:0] e_row = 0;
    logic [3:0] e_col = 0;
    logic [7:0] e_chr = 0;
    logic [N-1:0] e_done = '0;
    logic       e_ovf = 0;
    logic       e_tmo = 0;

    always @(posedge clk or negedge rst_n) begin
        bit busy_now [N];
        int g;
        bit ovf_ev, tmo_ev;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_row[i] = 0; m_col[i] = 0; m_chr[i] = 0;
            end
            m_fly = 0; m_owner = 0; m_ptr = 0; m_edges = 0;
            e_drv_req = 0; e_row = 0; e_col = 0; e_chr = 0;
            e_done = '0; e_ovf = 0; e_tmo = 0;
        end else begin
            for (int i = 0; i < N; i++) busy_now[i] = m_pend[i] || (m_fly && m_owner == i);
            e_drv_req = 0; e_done = '0; ovf_ev = 0; tmo_ev = 0; g = -1;
            if (m_fly) begin
                m_edges++;
                if (bus.drv_done === 1'b1 || m_edges == T) begin
                    if (bus.drv_done !== 1'b1) tmo_ev = 1;
                    e_done[m_owner] = 1'b1;
                    m_fly = 0;
                    m_ptr = (m_owner + 1) % N;
                end
            end else if (bus.drv_busy === 1'b0) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (g >= 0) begin
                e_drv_req = 1; e_row = m_row[g]; e_col = m_col[g]; e_chr = m_chr[g];
                m_fly = 1; m_owner = g; m_edges = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (!bus.req_en[i]) m_pend[i] = 0;
                else if (bus.req_valid[i]) begin
                    if (busy_now[i]) ovf_ev = 1;
                    else begin
                        m_pend[i] = 1;
                        m_row[i] = bus.req_row_flat[2*i +: 2];
                        m_col[i] = bus.req_col_flat[4*i +: 4];
                        m_chr[i] = bus.req_char_flat[8*i +: 8];
                    end
                end
            end
            if (g >= 0) m_pend[g] = 0;
            e_ovf = (e_ovf && !err_clr) || ovf_ev;
            e_tmo = (e_tmo && !err_clr) || tmo_ev;
        end
    end

    // Every-cycle comparison against the model while out of reset.
    logic [N-1:0] e_busy;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) e_busy[i] = m_pend[i] || (m_fly && m_owner == i);
            check("m_drv_req", bus.drv_req, e_drv_req);
            check("m_drv_row", bus.drv_row, e_row);
            check("m_drv_col", bus.drv_col, e_col);
            check("m_drv_char", bus.drv_char, e_chr);
            check("m_req_done", bus.req_done, e_done);
            check("m_req_busy", bus.req_busy, e_busy);
            check("m_ovf_err", ovf_err, e_ovf);
            check("m_tmo_err", tmo_err, e_tmo);
        end
    end

    // ---------------- LCD driver responder ----------------
    int drv_lat = 3;   // 0: never answers
    int rcnt = 0;
    always @(negedge clk) begin
        bus.drv_done = 1'b0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) bus.drv_done = 1'b1;
        end
        if (bus.drv_req === 1'b1 && drv_lat > 0) rcnt = drv_lat;
    end

    logic [7:0] glog [$];
    always @(negedge clk) if (rst_n && bus.drv_req === 1'b1) glog.push_back(bus.drv_char);

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
        bus.req_row_flat[2*i +: 2]  = r;
        bus.req_col_flat[4*i +: 4]  = c;
        bus.req_char_flat[8*i +: 8] = ch;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        bus.req_valid = m;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic wait_done(input int i, input int bound, output int cyc);
        cyc = 0;
        while (bus.req_done[i] !== 1'b1 && cyc < bound) begin tick(); cyc++; end
        check("done_seen", bus.req_done[i], 1'b1);
    endtask

    task automatic wait_req(input logic [7:0] ch, input int bound);
        int cyc = 0;
        while (!(bus.drv_req === 1'b1 && bus.drv_char === ch) && cyc < bound) begin tick(); cyc++; end
        check("req_seen", {bus.drv_req, bus.drv_char}, {1'b1, ch});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, n0;
        bus.req_en = '1; bus.req_valid = '0; bus.drv_busy = 1'b0;
        bus.req_row_flat = '0; bus.req_col_flat = '0; bus.req_char_flat = '0;
        tick(3);
        check("rst_drv_req", bus.drv_req, 0);
        check("rst_busy", bus.req_busy, 0);
        check("rst_done", bus.req_done, 0);
        check("rst_char", bus.drv_char, 0);
        check("rst_errs", {ovf_err, tmo_err}, 0);
        #2 rst_n = 1'b1;
        tick(2);

        // single write
        set_data(1, 2'd1, 4'd5, 8'h41);
        pulse(4'b0010);
        check("sw_busy", bus.req_busy[1], 1);
        tick();
        check("sw_drv_req", bus.drv_req, 1);
        check("sw_data", {bus.drv_row, bus.drv_col, bus.drv_char}, {2'd1, 4'd5, 8'h41});
        wait_done(1, 20, cyc);
        check("sw_done_lat", cyc, 4);
        check("sw_done_only1", bus.req_done, 4'b0010);
        check("sw_busy_low", bus.req_busy[1], 0);

        // move rr_ptr to 0 via requester 3
        set_data(3, 2'd0, 4'd3, 8'h33);
        pulse(4'b1000);
        wait_done(3, 30, cyc);
        tick(2);

        // round robin 0,2,3 then re-pulsed 0
        set_data(0, 2'd0, 4'd0, 8'h30);
        set_data(2, 2'd1, 4'd2, 8'h32);
        n0 = glog.size();
        pulse(4'b1101);
        wait_req(8'h32, 40);
        pulse(4'b0001);
        cyc = 0;
        while (glog.size() < n0 + 4 && cyc < 100) begin tick(); cyc++; end
        check("rr_count", glog.size() - n0, 4);
        check("rr_order", {glog[n0], glog[n0+1], glog[n0+2], glog[n0+3]}, 32'h30323330);
        wait_done(0, 20, cyc);
        tick(2);

        // overflow
        bus.drv_busy = 1'b1;
        set_data(2, 2'd0, 4'd7, 8'h61);
        pulse(4'b0100);
        set_data(2, 2'd1, 4'd8, 8'h62);
        pulse(4'b0100);
        check("ovf_set", ovf_err, 1);
        n0 = glog.size();
        tick(2);
        bus.drv_busy = 1'b0;
        wait_done(2, 30, cyc);
        tick(3);
        check("ovf_one_issue", glog.size() - n0, 1);
        check("ovf_first_char", glog[n0], 8'h61);
        check("ovf_sticky", ovf_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_clr", ovf_err, 0);

        // disable while pending
        bus.drv_busy = 1'b1;
        set_data(3, 2'd1, 4'd1, 8'h71);
        pulse(4'b1000);
        check("dis_busy_pend", bus.req_busy[3], 1);
        bus.req_en[3] = 1'b0;
        tick();
        check("dis_busy_clr", bus.req_busy[3], 0);
        bus.req_en[3] = 1'b1;
        n0 = glog.size();
        bus.drv_busy = 1'b0;
        tick(6);
        check("dis_no_issue", glog.size() - n0, 0);

        // disable while in flight
        drv_lat = 5;
        set_data(3, 2'd0, 4'd9, 8'h72);
        pulse(4'b1000);
        wait_req(8'h72, 10);
        bus.req_en[3] = 1'b0;
        wait_done(3, 20, cyc);
        check("dis_fly_done", bus.req_done, 4'b1000);
        bus.req_en[3] = 1'b1;
        drv_lat = 3;
        tick(2);

        // watchdog: driver never answers
        drv_lat = 0;
        set_data(1, 2'd1, 4'hA, 8'h81);
        set_data(2, 2'd0, 4'hB, 8'h82);
        pulse(4'b0110);
        wait_req(8'h81, 5);
        wait_done(1, 20, cyc);
        check("tmo_lat", cyc, 8);
        check("tmo_flag", tmo_err, 1);
        tick();
        check("tmo_next_req", {bus.drv_req, bus.drv_char}, {1'b1, 8'h82});
        wait_done(2, 20, cyc);
        check("tmo_lat2", cyc, 8);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_clr", tmo_err, 0);
        drv_lat = 3;

        // reset during WAIT, late drv_done ignored
        drv_lat = 4;
        set_data(0, 2'd1, 4'd3, 8'h91);
        pulse(4'b0001);
        wait_req(8'h91, 5);
        tick();
        #2 rst_n = 1'b0;
        tick();
        check("mid_rst_drv_req", bus.drv_req, 0);
        check("mid_rst_busy", bus.req_busy, 0);
        check("mid_rst_done", bus.req_done, 0);
        check("mid_rst_data", {bus.drv_row, bus.drv_col, bus.drv_char}, 0);
        tick();
        #2 rst_n = 1'b1;
        drv_lat = 3;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("late_done_ignored", {bus.req_done, bus.drv_req}, 0);
        end

        // drv_busy gates grants
        bus.drv_busy = 1'b1;
        set_data(0, 2'd0, 4'd1, 8'hA1);
        n0 = glog.size();
        pulse(4'b0001);
        tick(8);
        check("gate_no_req", glog.size() - n0, 0);
        check("gate_busy", bus.req_busy[0], 1);
        bus.drv_busy = 1'b0;
        wait_done(0, 20, cyc);
        check("gate_after", glog.size() - n0, 1);
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Shares the single character-write port of the LCD driver among up to N UI screens (menu selectors, morse entry, status views). Each screen issues one-character write pulses (`row`, `col`, `char`) and waits for `done`. The arbiter buffers one write per requester, grants round-robin, runs the req/busy/done handshake toward the driver, and routes `done` back to the owner. A watchdog keeps a requester from hanging on a lost `done`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 65535: cycles in WAIT before the transaction is aborted, ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset. One clock domain; reset polarity and asynchronous assertion are fixed.
- `req_en`  in  N_REQ  per-requester enable; tie to the screen's `is_active`.
- `req_valid`  in  N_REQ  one-cycle write pulse per requester.
- `req_row_flat`  in  2·N_REQ  requester i at `[2i+:2]`.
- `req_col_flat`  in  4·N_REQ  requester i at `[4i+:4]`.
- `req_char_flat`  in  8·N_REQ  requester i at `[8i+:8]`.
- `req_busy`  out  N_REQ  requester i has a write pending or in flight.
- `req_done`  out  N_REQ  one-cycle completion pulse to the owner.
- `drv_req`  out  1  one-cycle write pulse to the LCD driver.
- `drv_row` / `drv_col` / `drv_char`  out  2/4/8  write data, held stable from `drv_req` until completion.
- `drv_busy`  in  1  driver busy.
- `drv_done`  in  1  driver completion pulse.
- `err_clr`  in  1  clears the sticky error flags.
- `ovf_err`  out  1  sticky: a write was dropped.
- `tmo_err`  out  1  sticky: the watchdog fired.

## Operation
- **Pending slots.** Each requester i has one slot: `pend[i]` plus latched row/col/char.
  - Sampling `req_valid[i] & req_en[i] & ~req_busy[i]` sets the slot and latches the data.
  - Sampling `req_valid[i] & req_en[i] & req_busy[i]` drops the write and sets `ovf_err`.
  - `req_valid[i]` with `req_en[i]=0` is ignored silently.
  - `req_en[i]` low clears `pend[i]`. A write already in flight still completes, and its `req_done` is still pulsed.
- **`req_busy[i]`** = `pend[i] | (state≠IDLE & owner==i)`. It is combinational from registers only.
- **FSM states: IDLE, WAIT.**
  - IDLE, when any `pend` is set and `drv_busy=0`:
    - grant the first pending index at or after `rr_ptr`, ascending with wrap;
    - load `drv_*` from that slot, assert `drv_req` for 1 cycle;
    - clear that `pend`, record `owner`, clear the timeout counter;
    - go to WAIT.
  - WAIT, on `drv_done`: pulse `req_done[owner]`, set `rr_ptr` = owner+1 mod N_REQ, go to IDLE.
  - WAIT, when the counter reaches TIMEOUT_CYC−1 without `drv_done`: pulse `req_done[owner]`, set `tmo_err`, advance `rr_ptr` the same way, go to IDLE.
- **Counter.** Width is `$clog2(TIMEOUT_CYC)`. It saturates and never wraps.
- **Error flags.** `err_clr` clears both. If `err_clr` and a new error event occur in the same cycle, the error wins.
- **Reset values.** All outputs 0, `drv_*` 0, `rr_ptr` 0, state IDLE, all slots empty.
  - Reset mid-transaction discards everything, with no `req_done` pulse.
  - A `drv_done` arriving after reset is ignored, because `drv_done` in IDLE is ignored.

## Timing
- `req_valid` sampled at edge E0:
  - `req_busy` is high after E0;
  - `drv_req` is high for the cycle after E1 when the driver is idle and there is no contention.
- `drv_done` sampled at edge D: `req_done` is high for exactly the cycle after D, and `req_busy` is low in that same cycle.
- The earliest next grant samples IDLE at edge D+1, so there is at least 1 idle cycle between consecutive `drv_req` pulses.
- A new `req_valid` from requester i in the same cycle as its `req_done` is accepted, because `req_busy` is already low.
- `drv_done` in the same edge as the grant is ignored, because the FSM is still in IDLE.
- The `drv_*` data never changes while in WAIT.

## Structure
- Shared package `lcd_pkg`: FSM state encoding (`LCD_ARB_IDLE`, `LCD_ARB_WAIT`) and the LCD geometry constants `LCD_ROWS=2` and `LCD_COLS=16`, reused by the screens.
- One sub-module, `rr_pick #(N)`: combinational round-robin first-set search. Inputs are the `pend` vector and `rr_ptr`; outputs are `idx` and `any`.

## Test plan
- **Single write.** Requester 1 pulses `(row=1, col=5, char=0x41)` with the driver idle.
  - `drv_req` appears 2 cycles later carrying 1/5/0x41.
  - `drv_done` returned 3 cycles later gives `req_done[1]` on the next cycle.
  - No other `req_done` bit pulses.
- **Round-robin.** Requesters 0, 2 and 3 pulse in the same cycle, with `rr_ptr` at 0.
  - Grant order is 0, 2, 3.
  - Re-pulsing requester 0 during 2's service puts it after 3.
- **Overflow.** Requester 2 pulses twice while pending.
  - Only the first write is issued.
  - `ovf_err`=1 until `err_clr`.
- **Disable.** Requester 3 is pending, then `req_en[3]` drops before its grant.
  - Its write is never issued and `req_busy[3]`=0.
  - Repeat while in flight: `req_done[3]` is still pulsed.
- **Timeout.** `TIMEOUT_CYC=8` and the driver never asserts `drv_done`.
  - `req_done[owner]` pulses and `tmo_err`=1 after 8 WAIT cycles.
  - The next pending requester is then granted.
- **Reset and busy gating.**
  - Assert `rst_n` low during WAIT: all outputs are 0 and the late `drv_done` is ignored.
  - With `drv_busy` held high, no `drv_req` is issued even though `pend` is set.
